// File: rtl/msb_decode_nbit.sv
// msb_decode_nbit
//   Rebuilds an N-bit word from a 1-based MSB position, which makes it the
//   inverse of the MSB-position finder. A position of 0 means "zero word".
//   The word is produced as either a one-hot value or a thermometer mask.
//   It is a two-stage valid/ready pipeline. Stage 1 splits the position
//   into a byte group and a bit within that byte. Stage 2 expands each byte
//   lane from that pair.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   block accepts a request this cycle
//   in_pos     1-based MSB position (0 = zero word)
//   in_mode    0 = one-hot, 1 = thermometer mask
//   out_valid  result present
//   out_ready  consumer accepts the result this cycle
//   out_num    decoded N-bit word
//   out_err    request position was greater than N
module msb_decode_nbit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_pos,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_num,
  output logic         out_err
);

  localparam int NG  = N / 8;
  localparam int GIW = (NG > 1) ? $clog2(NG) : 1;

  // Expands (group, bit) into the full word. Lanes below the selected group
  // are all ones in mask mode. The selected lane gets a single bit in one-hot
  // mode, or bits b..0 in mask mode. The 9-bit intermediate lets b = 7
  // produce 8'hFF without wrapping.
  function automatic logic [N-1:0] decode_word(
    input logic           mode,
    input logic           zero,
    input logic           err,
    input logic [GIW-1:0] g,
    input logic [2:0]     b
  );
    logic [N-1:0] w;
    logic [7:0]   onehot_byte;
    logic [7:0]   mask_byte;
    w           = '0;
    onehot_byte = 8'd1 << b;
    mask_byte   = 8'((9'd2 << b) - 9'd1);
    if (!zero && !err) begin
      for (int k = 0; k < NG; k++) begin
        if (GIW'(k) == g)
          w[8*k +: 8] = mode ? mask_byte : onehot_byte;
        else if (mode && (GIW'(k) < g))
          w[8*k +: 8] = 8'hFF;
      end
    end
    return w;
  endfunction

  logic           vld_p1;
  logic           mode_p1;
  logic           zero_p1;
  logic           err_p1;
  logic [GIW-1:0] grp_p1;
  logic [2:0]     bit_p1;

  logic           s2_advance;
  logic [7:0]     pos_m1;
  logic           pos_zero;
  logic           pos_err;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !vld_p1 || s2_advance;

  assign pos_m1   = in_pos - 8'd1;
  assign pos_zero = (in_pos == 8'd0);
  assign pos_err  = ({1'b0, in_pos} > 9'(N));

  // Stage 1: split the position into byte group and in-byte bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      mode_p1 <= 1'b0;
      zero_p1 <= 1'b0;
      err_p1  <= 1'b0;
      grp_p1  <= '0;
      bit_p1  <= '0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        mode_p1 <= in_mode;
        zero_p1 <= pos_zero;
        err_p1  <= pos_err;
        grp_p1  <= GIW'(pos_m1 >> 3);
        bit_p1  <= pos_m1[2:0];
      end
    end
  end

  // Stage 2: expand each byte lane and register the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_num   <= '0;
      out_err   <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_num <= decode_word(mode_p1, zero_p1, err_p1, grp_p1, bit_p1);
        out_err <= err_p1;
      end
    end
  end

endmodule

// File: doc/msb_decode_nbit.md
# msb_decode_Nbit

Inverse of the MSB-position finder: accepts a 1-based bit position (0 = "no bit set") and rebuilds an N-bit word whose most significant set bit is at that position. Output is either a one-hot word or a thermometer mask. The block is a 2-stage valid/ready pipeline, split into byte-group select and in-byte decode, the same 8-bit partitioning the finder uses. It sits on the producer side of the finder, so finder(decoder(p)) == p for every legal p.

## Interface
- N, 32, output word width; multiple of 8, 8..248 (must be representable by 8-bit position)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block accepts request this cycle
- in_pos  in  8  1-based MSB position; 0 = zero word
- in_mode  in  1  0 = one-hot, 1 = thermometer mask (bits pos-1..0 set)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- out_num  out  N  decoded word
- out_err  out  1  in_pos > N (out-of-range)

## Operation
- Transfer on either side occurs when valid && ready are both high at a rising clk edge.
- Decode rules:
  - pos = 0: out_num = 0, out_err = 0.
  - 1 ≤ pos ≤ N, mode 0: out_num = 1 << (pos-1), out_err = 0.
  - 1 ≤ pos ≤ N, mode 1: out_num = (1 << pos) - 1, out_err = 0. Computed without overflow for pos = N, giving all ones.
  - pos > N: out_num = 0, out_err = 1, for either mode.
- Stage 1 registers:
  - s1_valid, mode, zero flag, err flag.
  - group g = (pos-1) >> 3, width ceil(log2(N/8)), minimum 1.
  - bit b = (pos-1) & 7.
- Stage 2 registers out_valid, out_num and out_err:
  - Per group k, the byte is computed from g and b.
  - One-hot: byte k = (k == g) ? 1<<b : 0.
  - Mask: byte k = k < g ? 8'hFF : k == g ? (2<<b)-1 : 0.
  - The zero flag or err flag forces all bytes to 0.
- Flow control, stall-propagating with no bubbles:
  - s2_advance = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_advance (combinational, no dependency on in_valid).
  - Stage 2 loads stage 1 when s2_advance. out_valid <= s1_valid.
  - Stage 1 loads input when in_ready. s1_valid <= in_valid.
- While out_valid && !out_ready: out_num and out_err are held stable, and stage 1 holds its contents.
- Results emerge in request order. There is no drop and no duplication.

## Timing
- Reset (rst_n low, asynchronous): s1_valid = 0, out_valid = 0, out_num = 0, out_err = 0, stage-1 data = 0.
- in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight requests immediately. No output handshake completes for them.
- Latency: a request accepted at edge t drives out_valid high after edge t+1, for consumption at edge t+2 if out_ready is high.
- Throughput: 1 request per cycle with out_ready held high.
- Full condition: both stages valid and out_ready low forces in_ready low in the same cycle.
- Simultaneous events: on a full pipeline with out_ready = 1 and in_valid = 1, the output retires, stage 1 moves to stage 2 and a new input loads into stage 1, all at the same edge.
- Output data is don't-care when out_valid = 0 but must remain at its last loaded value (no X).

## Test plan
- Reset, then pos = 0, 1, 8, 9, 32 with mode 0 and out_ready = 1. Required outputs, 2 cycles after each accept:
  - 0x00000000, 0x00000001, 0x00000080, 0x00000100, 0x80000000.
  - out_err = 0 for all five.
- Mode 1 with pos = 1, 9, 17, 32. Required outputs: 0x00000001, 0x000001FF, 0x0001FFFF, 0xFFFFFFFF.
- Out-of-range pos = 33 and pos = 255, both modes. Required: out_num = 0, out_err = 1.
- Back-to-back stream of pos 1..32 with out_ready low during cycles 5–8:
  - in_ready drops once both stages are full.
  - out_num is stable during the stall.
  - All 32 results arrive in order with no gaps after the stall ends.
- Assert rst_n low while 2 requests are in flight:
  - out_valid and out_num go to 0 asynchronously.
  - No stale result appears after reset is released.
- Round trip with N = 64:
  - Random pos 0..64, mode 0, feed out_num into the MSB finder.
  - The finder's output equals pos for all inputs, across 1000 random vectors.
